led_pattern_gen: RTL and testbench

Parametrised successor to the single-pattern flowing-LED driver. It drives an LED_W-bit LED bank from a shared step timer and supports four runtime-selectable patterns: rotate left, rotate right, bounce, and fill/drain. It also adds a step enable, glitch-free mode switching and a step strobe for downstream sequencing. The block sits directly on the board LED pins, next to the system clock/reset tree.

---
 rtl/led_pattern_gen.sv | 129 ++++++++++++
 tb/tb_led_pattern_gen.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : led_pattern_gen
// Description : Multi-pattern LED bank driver with a shared step timer.
//               Patterns: rotate left, rotate right, bounce, fill/drain.
//               Provides a step enable, immediate mode reload and a
//               registered one-cycle step strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_gen #(
    parameter int unsigned           LED_W   = 8,
    parameter int unsigned           CNT_W   = 24,
    parameter logic [CNT_W-1:0]      CNT_MAX = 24'd2
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic [LED_W-1:0] led_out,
    output logic             step
);

    // Pattern selection codes
    localparam logic [1:0] MODE_ROL    = 2'd0;
    localparam logic [1:0] MODE_ROR    = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_FILL   = 2'd3;

    // Fill/drain phase encoding
    localparam logic [0:0] PH_FILL  = 1'b0;
    localparam logic [0:0] PH_DRAIN = 1'b1;

    // Bounce direction encoding
    localparam logic [0:0] DIR_LEFT  = 1'b0;
    localparam logic [0:0] DIR_RIGHT = 1'b1;

    // Seeds: lowest LED for most patterns, highest LED for rotate right
    localparam logic [LED_W-1:0] SEED_LSB = LED_W'(1);
    localparam logic [LED_W-1:0] SEED_MSB = SEED_LSB << (LED_W - 1);

    logic [CNT_W-1:0] counter_q, counter_d;
    logic [1:0]       mode_q,    mode_d;
    logic [0:0]       dir_q,     dir_d;
    logic [0:0]       phase_q,   phase_d;
    logic [LED_W-1:0] led_q,     led_d;
    logic             step_q,    step_d;

    // Next-state: mode reload beats the enable; terminal count advances the pattern
    always_comb begin
        counter_d = counter_q;
        mode_d    = mode_q;
        dir_d     = dir_q;
        phase_d   = phase_q;
        led_d     = led_q;
        step_d    = 1'b0;

        if (mode != mode_q) begin
            // Any mode change reloads the seed immediately, even with en low
            mode_d    = mode;
            led_d     = (mode == MODE_ROR) ? SEED_MSB : SEED_LSB;
            counter_d = '0;
            dir_d     = DIR_LEFT;
            phase_d   = PH_FILL;
        end else if (en) begin
            if (counter_q != CNT_MAX) begin
                counter_d = counter_q + CNT_W'(1);
            end else begin
                counter_d = '0;
                step_d    = 1'b1;
                case (mode_q)
                    MODE_ROL: begin
                        led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
                    end
                    MODE_ROR: begin
                        led_d = {led_q[0], led_q[LED_W-1:1]};
                    end
                    MODE_BOUNCE: begin
                        // Direction turns as soon as an end LED becomes lit,
                        // so each end LED is shown for a single step
                        if (dir_q == DIR_LEFT) begin
                            led_d = {led_q[LED_W-2:0], 1'b0};
                            if (led_d[LED_W-1]) begin
                                dir_d = DIR_RIGHT;
                            end
                        end else begin
                            led_d = {1'b0, led_q[LED_W-1:1]};
                            if (led_d[0]) begin
                                dir_d = DIR_LEFT;
                            end
                        end
                    end
                    default: begin
                        // Fill shifts ones in from the bottom, drain shifts zeros
                        led_d = {led_q[LED_W-2:0], (phase_q == PH_FILL)};
                        if ((phase_q == PH_FILL) && (&led_d)) begin
                            phase_d = PH_DRAIN;
                        end else if ((phase_q == PH_DRAIN) && !(|led_d)) begin
                            phase_d = PH_FILL;
                        end
                    end
                endcase
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            counter_q <= '0;
            mode_q    <= MODE_ROL;
            dir_q     <= DIR_LEFT;
            phase_q   <= PH_FILL;
            led_q     <= SEED_LSB;
            step_q    <= 1'b0;
        end else begin
            counter_q <= counter_d;
            mode_q    <= mode_d;
            dir_q     <= dir_d;
            phase_q   <= phase_d;
            led_q     <= led_d;
            step_q    <= step_d;
        end
    end

    assign led_out = led_q;
    assign step    = step_q;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_pattern_gen
// Description : Self-checking bench for led_pattern_gen (LED_W=8, CNT_MAX=2).
//               Directed scenarios followed by randomized en/mode/reset
//               traffic, all compared against an index-based pattern model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pattern_gen;

    localparam int CMAX = 2;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       en;
    logic [1:0] mode;
    logic [7:0] led_out;
    logic       step;

    int checks   = 0;
    int failures = 0;

    // Model state: active mode, number of steps taken since load, timer count
    int   m_mode;
    int   m_k;
    int   m_cnt;
    logic m_step;

    logic [7:0] seq2 [0:15] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    logic [7:0] seq3 [0:16] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                                8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00,
                                8'h01};

    led_pattern_gen #(
        .LED_W   (8),
        .CNT_W   (24),
        .CNT_MAX (24'd2)
    ) u_dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .en        (en),
        .mode      (mode),
        .led_out   (led_out),
        .step      (step)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // LED image after k steps of a pattern, from its closed-form description
    function automatic logic [7:0] pattern(input int md, input int k);
        int p;
        int v;
        case (md)
            0: v = 1 << (k % 8);
            1: v = 8'h80 >> (k % 8);
            2: begin
                p = k % 14;
                v = (p < 8) ? (1 << p) : (1 << (14 - p));
            end
            default: begin
                p = k % 16;
                v = (p < 8) ? ((1 << (p + 1)) - 1) : ((8'hFF << (p - 7)) & 8'hFF);
            end
        endcase
        return v[7:0];
    endfunction

    // One clock edge: advance the model with the sampled inputs, then compare
    task automatic tick();
        @(posedge sys_clk);
        if (!sys_rst_n) begin
            m_mode = 0; m_k = 0; m_cnt = 0; m_step = 1'b0;
        end else if (int'(mode) != m_mode) begin
            m_mode = int'(mode); m_k = 0; m_cnt = 0; m_step = 1'b0;
        end else if (!en) begin
            m_step = 1'b0;
        end else if (m_cnt < CMAX) begin
            m_cnt++; m_step = 1'b0;
        end else begin
            m_cnt = 0; m_k++; m_step = 1'b1;
        end
        #1;
        check_val("led_model", {24'd0, led_out}, {24'd0, pattern(m_mode, m_k)});
        check_val("step_model", {31'd0, step}, {31'd0, m_step});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        m_mode = 0; m_k = 0; m_cnt = 0; m_step = 1'b0;
        sys_rst_n = 1'b0;
        en        = 1'b1;
        mode      = 2'd0;

        // 1: reset state, first step on 3rd edge, wrap after 8 steps
        ticks(2);
        check_val("reset_led", {24'd0, led_out}, 32'h01);
        check_val("reset_step", {31'd0, step}, 32'd0);
        sys_rst_n = 1'b1;
        ticks(2);
        check_val("t1_pre_step", {31'd0, step}, 32'd0);
        tick();
        check_val("t1_first_led", {24'd0, led_out}, 32'h02);
        check_val("t1_first_step", {31'd0, step}, 32'd1);
        tick();
        check_val("t1_step_one_cycle", {31'd0, step}, 32'd0);
        ticks(20);
        check_val("t1_wrap_led", {24'd0, led_out}, 32'h01);
        check_val("t1_wrap_step", {31'd0, step}, 32'd1);

        // 2: rotate right seed and first steps
        mode = 2'd1;
        tick();
        check_val("t2_seed", {24'd0, led_out}, 32'h80);
        check_val("t2_seed_step", {31'd0, step}, 32'd0);
        ticks(3);
        check_val("t2_step1", {24'd0, led_out}, 32'h40);
        ticks(3);
        check_val("t2_step2", {24'd0, led_out}, 32'h20);

        // 3: bounce sequence against the literal table
        mode = 2'd2;
        tick();
        check_val("t3_seq", {24'd0, led_out}, {24'd0, seq2[0]});
        for (int i = 1; i < 16; i++) begin
            ticks(3);
            check_val("t3_seq", {24'd0, led_out}, {24'd0, seq2[i]});
        end

        // 4: fill/drain sequence against the literal table
        mode = 2'd3;
        tick();
        check_val("t4_seq", {24'd0, led_out}, {24'd0, seq3[0]});
        for (int i = 1; i < 17; i++) begin
            ticks(3);
            check_val("t4_seq", {24'd0, led_out}, {24'd0, seq3[i]});
        end

        // 5: freeze with en low from the terminal-count cycle, then resume
        ticks(2);
        en = 1'b0;
        ticks(10);
        check_val("t5_frozen", {24'd0, led_out}, 32'h01);
        en = 1'b1;
        tick();
        check_val("t5_resume_led", {24'd0, led_out}, 32'h03);
        check_val("t5_resume_step", {31'd0, step}, 32'd1);

        // 6a: mode 0 -> 2 in the step cycle
        mode = 2'd0;
        ticks(3);
        mode = 2'd2;
        tick();
        check_val("t6_switch_led", {24'd0, led_out}, 32'h01);
        check_val("t6_switch_step", {31'd0, step}, 32'd0);
        ticks(2);
        check_val("t6_no_early_step", {31'd0, step}, 32'd0);
        tick();
        check_val("t6_next_step_led", {24'd0, led_out}, 32'h02);
        check_val("t6_next_step", {31'd0, step}, 32'd1);

        // 6b: reset during fill/drain DRAIN phase
        mode = 2'd3;
        tick();
        ticks(27);
        check_val("t6_in_drain", {24'd0, led_out}, 32'hFC);
        sys_rst_n = 1'b0;
        tick();
        check_val("t6_rst_led", {24'd0, led_out}, 32'h01);
        sys_rst_n = 1'b1;
        tick();
        check_val("t6_reload_led", {24'd0, led_out}, 32'h01);
        ticks(3);
        check_val("t6_fill_after_rst", {24'd0, led_out}, 32'h03);

        // Mode toggling every cycle keeps reloading the seed
        for (int i = 0; i < 6; i++) begin
            mode = (i % 2 == 0) ? 2'd1 : 2'd2;
            tick();
        end

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            sys_rst_n = ($urandom_range(0, 199) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
